// File: rtl/uart_pkg.sv
// Shared UART receiver types and default frame parameters.
// No logic here; the FSM encoding lives in state_t.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 16;
    localparam int DATA_BITS_DEF    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line, resets to the idle level (1).
// Latency 2 cycles; no backpressure.
module uart_sync2 (
    input  logic clk_sis,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    always_ff @(posedge clk_sis or posedge rst) begin
        if (rst) begin
            ff_q <= 2'b11;
        end else begin
            ff_q <= {ff_q[0], d_i};
        end
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, DATA_BITS data (LSB first), 1 stop, no parity; pulses data_valid or framing_err.
// Latency (DATA_BITS+1.5)*CLKS_PER_BIT+3 cycles from the start edge; no backpressure, outputs are pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = DATA_BITS_DEF
) (
    input  logic                 clk_sis,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 framing_err,
    output logic                 busy
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 rx_prev_q;
    state_t               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;

    uart_sync2 u_sync (
        .clk_sis (clk_sis),
        .rst     (rst),
        .d_i     (rx),
        .q_o     (rx_s)
    );

    always_ff @(posedge clk_sis or posedge rst) begin
        if (rst) begin
            rx_prev_q <= 1'b1;
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_prev_q <= rx_s;
            state_q   <= state_d;
            timer_q   <= timer_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (rx_prev_q && !rx_s) state_d = ST_START;
            end
            ST_START: begin
                // Mid-bit recheck rejects glitches shorter than half a bit.
                if (timer_q == T_HALF) begin
                    timer_d = '0;
                    idx_d   = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_DATA: begin
                if (timer_q == T_LAST) begin
                    timer_d = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == I_LAST) state_d = ST_STOP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_STOP: begin
                if (timer_q == T_LAST) begin
                    timer_d = '0;
                    if (rx_s) begin
                        dout_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_IDLE;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != ST_IDLE);
        data_out    = dout_q;
        data_valid  = valid_q;
        framing_err = ferr_q;
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed scenarios plus randomized frames against a frame-level model.
module tb_uart_rx;

    localparam int CPB     = 16;
    localparam int DB      = 8;
    localparam int LAT_MIN = ((2 * DB + 3) * CPB) / 2 + 2;
    localparam int LAT_MAX = LAT_MIN + 2;

    logic          clk_sis = 1'b0;
    logic          rst     = 1'b1;
    logic          rx      = 1'b1;
    logic [DB-1:0] data_out;
    logic          data_valid;
    logic          framing_err;
    logic          busy;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk_sis     (clk_sis),
        .rst         (rst),
        .rx          (rx),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .framing_err (framing_err),
        .busy        (busy)
    );

    always #5 clk_sis = ~clk_sis;

    int cyc = 0;
    always @(posedge clk_sis) cyc++;

    typedef struct {
        bit            is_err;
        logic [DB-1:0] data;
        int            start;
    } exp_t;

    exp_t          sb[$];
    int            valid_times[$];
    int            tests = 0;
    int            fails = 0;
    logic [DB-1:0] last_good = '0;
    logic          prev_v = 1'b0;
    logic          prev_f = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every output pulse must match the oldest expected frame outcome.
    always @(negedge clk_sis) begin : monitor
        exp_t e;
        int   lat;
        if (!rst && (data_valid || framing_err)) begin
            check("pulse_exclusive", {31'd0, data_valid & framing_err}, 32'd0);
            check("pulse_width", {31'd0, (data_valid & prev_v) | (framing_err & prev_f)}, 32'd0);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: valid=%0b ferr=%0b data=0x%0h, expected no pulse (cycle %0d)",
                         data_valid, framing_err, data_out, cyc);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", {31'd0, framing_err}, {31'd0, e.is_err});
                if (data_valid && !e.is_err) begin
                    check("data_out", {24'd0, data_out}, {24'd0, e.data});
                    lat = cyc - e.start;
                    tests++;
                    if (lat < LAT_MIN || lat > LAT_MAX) begin
                        fails++;
                        $display("FAIL latency: got %0d cycles, expected %0d..%0d", lat, LAT_MIN, LAT_MAX);
                    end
                    last_good = e.data;
                    valid_times.push_back(cyc);
                end else if (framing_err) begin
                    check("data_hold", {24'd0, data_out}, {24'd0, last_good});
                end
            end
        end
        prev_v = data_valid;
        prev_f = framing_err;
    end

    task automatic bit_time(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk_sis);
    endtask

    // Drives one frame starting at a negedge; the line is left at the stop-bit level.
    task automatic send(input logic [DB-1:0] d, input logic stop);
        exp_t e;
        e.is_err = !stop;
        e.data   = d;
        e.start  = cyc;
        sb.push_back(e);
        bit_time(1'b0);
        for (int i = 0; i < DB; i++) bit_time(d[i]);
        bit_time(stop);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk_sis);
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d outcomes outstanding, expected 0", sb.size());
            sb.delete();
        end
        repeat (4) @(negedge clk_sis);
    endtask

    initial begin : main
        logic [DB-1:0] d;
        bit            ok;
        int            hi;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk_sis);
        check("reset_data_out", {24'd0, data_out}, 32'd0);
        check("reset_valid", {31'd0, data_valid}, 32'd0);
        check("reset_ferr", {31'd0, framing_err}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk_sis);

        send(8'h5B, 1'b1);
        bit_time(1'b1);
        wait_drain();

        valid_times.delete();
        send(8'hA5, 1'b1);
        send(8'h00, 1'b1);
        bit_time(1'b1);
        wait_drain();
        check("b2b_count", valid_times.size(), 32'd2);
        if (valid_times.size() == 2)
            check("b2b_spacing", valid_times[1] - valid_times[0], 10 * CPB);

        // 4-cycle low glitch on an idle line
        hi = 0;
        rx = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 4) rx = 1'b1;
            @(negedge clk_sis);
            if (busy) hi++;
        end
        tests++;
        if (hi < 7 || hi > 9) begin
            fails++;
            $display("FAIL glitch_busy_width: got %0d cycles, expected 7..9", hi);
        end
        check("glitch_busy_end", {31'd0, busy}, 32'd0);

        // bad stop bit followed by a break
        send(8'h3C, 1'b0);
        repeat (3 * CPB) @(negedge clk_sis);
        rx = 1'b1;
        repeat (6) @(negedge clk_sis);
        check("break_busy_low", {31'd0, busy}, 32'd0);
        wait_drain();
        send(8'h81, 1'b1);
        bit_time(1'b1);
        wait_drain();

        // reset in the middle of data bit 3 of 0xFF
        rx = 1'b0;
        repeat (CPB) @(negedge clk_sis);
        rx = 1'b1;
        repeat (3 * CPB + CPB / 2) @(negedge clk_sis);
        rst = 1'b1;
        #1;
        check("midrst_data_out", {24'd0, data_out}, 32'd0);
        check("midrst_valid", {31'd0, data_valid}, 32'd0);
        check("midrst_ferr", {31'd0, framing_err}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        last_good = '0;
        @(negedge clk_sis);
        rst = 1'b0;
        repeat (CPB / 2 + 5 * CPB) @(negedge clk_sis);
        check("midrst_idle", {31'd0, busy}, 32'd0);
        send(8'h12, 1'b1);
        bit_time(1'b1);
        wait_drain();

        // randomized frames, mixed gaps and stop-bit errors
        for (int n = 0; n < 24; n++) begin
            d  = DB'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            send(d, ok);
            if (!ok) begin
                repeat ($urandom_range(0, 2) * CPB) @(negedge clk_sis);
                bit_time(1'b1);
            end else begin
                repeat ($urandom_range(0, 2)) bit_time(1'b1);
            end
        end
        bit_time(1'b1);
        wait_drain();
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, gives the number of clk_sis cycles per UART bit; it SHALL be even and at least 4.
REQ-002 Parameter DATA_BITS, default 8, gives the number of data bits per frame.
REQ-003 Port clk_sis, input, 1 bit: the single system clock; all flops SHALL be rising-edge clk_sis.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port rx, input, 1 bit: serial line, asynchronous to clk_sis; idle high.
REQ-006 Port data_out, output, DATA_BITS bits: last correctly framed byte, LSB received first.
REQ-007 Port data_valid, output, 1 bit: one-cycle pulse when data_out is updated.
REQ-008 Port framing_err, output, 1 bit: one-cycle pulse when the stop bit samples low.
REQ-009 Port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer before any use; rx_s is the synchronized signal.
REQ-011 Frame format SHALL be 1 start bit (0), DATA_BITS data bits (LSB first), 1 stop bit (1), no parity.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-013 In IDLE, a falling edge on rx_s (1 then 0 on consecutive cycles) SHALL move the FSM to START and clear the bit-timer.
REQ-014 START SHALL re-sample rx_s when the bit-timer reaches CLKS_PER_BIT/2-1.
- If rx_s is 0: the FSM SHALL go to DATA, clear the timer and clear the bit index.
- If rx_s is 1: the glitch SHALL be discarded, the FSM SHALL return to IDLE, and no output SHALL pulse.
REQ-015 DATA SHALL sample rx_s each time the timer reaches CLKS_PER_BIT-1, shift the sample into a shift register MSB-side (so that after the last bit the LSB holds the first bit received), increment the bit index and clear the timer.
REQ-016 After DATA_BITS samples, the FSM SHALL go to STOP.
REQ-017 STOP SHALL sample rx_s when the timer reaches CLKS_PER_BIT-1.
- If rx_s is 1: data_out SHALL load the shift register, data_valid SHALL pulse on the next cycle, and the FSM SHALL go to IDLE.
- If rx_s is 0: framing_err SHALL pulse on the next cycle, data_out SHALL hold its value, and the FSM SHALL go to WAIT_IDLE.
REQ-018 WAIT_IDLE SHALL remain until rx_s is 1, then go to IDLE; a held-low line (break) SHALL produce exactly one framing_err pulse.
REQ-019 data_valid and framing_err SHALL never be high in the same cycle, and neither SHALL stay high for more than one cycle.
REQ-020 Back-to-back frames (a start bit immediately after the stop bit) SHALL be received without loss: IDLE is entered by the cycle after the stop sample, before the next falling edge reaches rx_s.
REQ-021 The bit-timer SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL never exceed CLKS_PER_BIT-1.
REQ-022 The bit index SHALL be $clog2(DATA_BITS+1) bits wide.
REQ-023 Latency: data_valid SHALL rise between (DATA_BITS+1.5)*CLKS_PER_BIT+2 and +4 cycles after the rx falling edge.

Reset
REQ-024 While rst is high, the following SHALL hold regardless of clock:
- FSM is in IDLE;
- synchronizer flops and the previous-sample flop are 1;
- timer, bit index and shift register are 0;
- data_out is 0; data_valid, framing_err and busy are 0.
REQ-025 A reset asserted mid-frame SHALL abort the frame with no output pulse; after release, reception SHALL restart only on a new falling edge.

Structure
REQ-026 Package uart_pkg SHALL hold the FSM state enumeration and the default CLKS_PER_BIT and DATA_BITS constants.
REQ-027 The synchronizer SHALL be the sub-module uart_sync2 (2 flops, asynchronous reset value 1); all other logic SHALL be in uart_rx.

Verification (CLKS_PER_BIT=16, DATA_BITS=8)
REQ-028 Frame 0x5B with a valid stop bit -> data_out=0x5B, one data_valid pulse, 154-156 cycles after the start edge; framing_err stays 0.
REQ-029 Frames 0xA5 then 0x00, back-to-back with no idle gap -> two data_valid pulses, exactly 160 cycles apart; data_out=0xA5 then 0x00.
REQ-030 Low glitch of 4 cycles on an idle line -> FSM returns to IDLE; no pulses; busy falls about 8 cycles after it rose.
REQ-031 Frame 0x3C with stop bit 0, line held low for 3 bit times, then high -> one framing_err pulse, data_out unchanged, busy low once the line returns high; a following 0x81 frame is then received correctly.
REQ-032 rst asserted for 1 cycle during data bit 3 of 0xFF -> all outputs 0 immediately; no data_valid pulse; a following 0x12 frame is received correctly.
